// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard sequencer: counts bubble windows for JAL, EX redirects and load-use stalls
// and drives the PC/IF-ID stall and IF-ID/ID-EX flush strobes with zero-latency detection.
module hazard_flush_ctrl #(
    parameter int unsigned JAL_BUBBLES = 2,
    parameter int unsigned BR_BUBBLES  = 2,
    parameter int unsigned LU_STALL    = 1,
    parameter int unsigned REG_AW      = 5,
    localparam int unsigned MAX_B = (JAL_BUBBLES > BR_BUBBLES)
                                  ? ((JAL_BUBBLES > LU_STALL) ? JAL_BUBBLES : LU_STALL)
                                  : ((BR_BUBBLES > LU_STALL) ? BR_BUBBLES : LU_STALL),
    localparam int unsigned CW    = $clog2(((MAX_B < 1) ? 1 : MAX_B) + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode_id_i,
    input  logic [REG_AW-1:0] rs1_id_i,
    input  logic [REG_AW-1:0] rs2_id_i,
    input  logic              ex_memr_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              redirect_ex_i,
    output logic              stall_pc_o,
    output logic              stall_ifid_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              insert_nop_o,
    output logic              busy_o,
    output logic [CW-1:0]     remain_o
);

    localparam logic [6:0]    OP_JAL  = 7'b1101111;
    localparam logic [CW-1:0] JAL_REM = CW'(JAL_BUBBLES - 1);
    localparam logic [CW-1:0] BR_REM  = CW'(BR_BUBBLES - 1);
    localparam logic [CW-1:0] LU_REM  = CW'(LU_STALL - 1);

    typedef enum logic [1:0] {IDLE, JFLUSH, BFLUSH, LSTALL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] remain_q, remain_d;
    logic          armed_q;
    logic          jal_det, br_det, lu_det;

    // Raw hazard detects; priority and state masking are applied in the FSM
    always_comb begin
        jal_det = (opcode_id_i == OP_JAL) && (JAL_BUBBLES > 0);
        br_det  = redirect_ex_i && (BR_BUBBLES > 0);
        lu_det  = ex_memr_i && (ex_rd_i != '0)
               && ((ex_rd_i == rs1_id_i) || (ex_rd_i == rs2_id_i))
               && (LU_STALL > 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            armed_q  <= 1'b1;
        end
    end

    // Outputs are silenced until the first clock edge after reset release
    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        stall_pc_o   = 1'b0;
        stall_ifid_o = 1'b0;
        flush_ifid_o = 1'b0;
        flush_idex_o = 1'b0;
        remain_o     = '0;
        if (armed_q) begin
            if (br_det) begin
                flush_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
                remain_o     = BR_REM;
                if (BR_BUBBLES > 1) begin
                    state_d  = BFLUSH;
                    remain_d = BR_REM;
                end else begin
                    state_d  = IDLE;
                    remain_d = '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (lu_det) begin
                            stall_pc_o   = 1'b1;
                            stall_ifid_o = 1'b1;
                            flush_idex_o = 1'b1;
                            remain_o     = LU_REM;
                            if (LU_STALL > 1) begin
                                state_d  = LSTALL;
                                remain_d = LU_REM;
                            end
                        end else if (jal_det) begin
                            flush_ifid_o = 1'b1;
                            remain_o     = JAL_REM;
                            if (JAL_BUBBLES > 1) begin
                                state_d  = JFLUSH;
                                remain_d = JAL_REM;
                            end
                        end
                    end
                    JFLUSH: flush_ifid_o = 1'b1;
                    BFLUSH: begin
                        flush_ifid_o = 1'b1;
                        flush_idex_o = 1'b1;
                    end
                    LSTALL: begin
                        stall_pc_o   = 1'b1;
                        stall_ifid_o = 1'b1;
                        flush_idex_o = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
                // Windows count down; ID-side detects are ignored while one is open
                if (state_q != IDLE) begin
                    remain_o = remain_q - CW'(1);
                    remain_d = remain_q - CW'(1);
                    if (remain_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    assign insert_nop_o = flush_ifid_o | flush_idex_o;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Randomised bench for hazard_flush_ctrl: three parameterisations share one stimulus stream
// and are compared each cycle against a window-based reference model.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, ex_rd;
    logic       ex_memr, redirect;
    logic [2:0] spc, sif, fif, fid, nop, bsy;
    logic [1:0] rem [3];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hazard_flush_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .opcode_id_i(opcode), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .ex_memr_i(ex_memr), .ex_rd_i(ex_rd), .redirect_ex_i(redirect),
        .stall_pc_o(spc[0]), .stall_ifid_o(sif[0]), .flush_ifid_o(fif[0]),
        .flush_idex_o(fid[0]), .insert_nop_o(nop[0]), .busy_o(bsy[0]), .remain_o(rem[0]));

    hazard_flush_ctrl #(.JAL_BUBBLES(3), .BR_BUBBLES(2), .LU_STALL(2)) u_long (
        .clk(clk), .rst_n(rst_n), .opcode_id_i(opcode), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .ex_memr_i(ex_memr), .ex_rd_i(ex_rd), .redirect_ex_i(redirect),
        .stall_pc_o(spc[1]), .stall_ifid_o(sif[1]), .flush_ifid_o(fif[1]),
        .flush_idex_o(fid[1]), .insert_nop_o(nop[1]), .busy_o(bsy[1]), .remain_o(rem[1]));

    hazard_flush_ctrl #(.JAL_BUBBLES(1), .BR_BUBBLES(0), .LU_STALL(3)) u_nobr (
        .clk(clk), .rst_n(rst_n), .opcode_id_i(opcode), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .ex_memr_i(ex_memr), .ex_rd_i(ex_rd), .redirect_ex_i(redirect),
        .stall_pc_o(spc[2]), .stall_ifid_o(sif[2]), .flush_ifid_o(fif[2]),
        .flush_idex_o(fid[2]), .insert_nop_o(nop[2]), .busy_o(bsy[2]), .remain_o(rem[2]));

    // Reference model: an open window is (kind, cycles still to come after the current one)
    localparam int K_NONE = 0, K_JAL = 1, K_BR = 2, K_LU = 3;
    int  jb [3] = '{2, 3, 1};
    int  bb [3] = '{2, 2, 0};
    int  ls [3] = '{1, 2, 3};
    int  kind [3], left [3], nkind [3], nleft [3];
    bit  armed;
    int  cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model(input int i, output logic [5:0] fl, output int r);
        int  act = K_NONE, n = 0;
        bit  start = 1'b0;
        bit  br, lu, jal;
        fl = '0;
        r  = 0;
        nkind[i] = kind[i];
        nleft[i] = left[i];
        if (!armed) begin
            nkind[i] = K_NONE;
            nleft[i] = 0;
            return;
        end
        br  = redirect && bb[i] > 0;
        lu  = ex_memr && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2) && ls[i] > 0;
        jal = opcode == 7'h6f && jb[i] > 0;
        if (br) begin
            act = K_BR; n = bb[i]; start = 1'b1;
        end else if (kind[i] != K_NONE) begin
            act = kind[i];
            r = left[i] - 1;
            nleft[i] = left[i] - 1;
            nkind[i] = (nleft[i] == 0) ? K_NONE : kind[i];
        end else if (lu) begin
            act = K_LU; n = ls[i]; start = 1'b1;
        end else if (jal) begin
            act = K_JAL; n = jb[i]; start = 1'b1;
        end
        if (start) begin
            r = n - 1;
            nkind[i] = (n > 1) ? act : K_NONE;
            nleft[i] = (n > 1) ? n - 1 : 0;
        end
        // flag order: stall_pc, stall_ifid, flush_ifid, flush_idex, insert_nop, busy
        fl[5] = (act == K_LU);
        fl[4] = (act == K_LU);
        fl[3] = (act == K_JAL) || (act == K_BR);
        fl[2] = (act == K_BR) || (act == K_LU);
        fl[1] = fl[3] | fl[2];
        fl[0] = (kind[i] != K_NONE);
    endfunction

    // Apply one cycle of inputs and check every instance on the falling edge
    task automatic drive(input bit r, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                         input bit m, input logic [4:0] d, input bit rd);
        logic [5:0] fl;
        int         er;
        rst_n = r; opcode = op; rs1 = a; rs2 = b; ex_memr = m; ex_rd = d; redirect = rd;
        if (!r) armed = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            model(i, fl, er);
            check($sformatf("flags_u%0d", i), 32'({spc[i], sif[i], fif[i], fid[i], nop[i], bsy[i]}), 32'(fl));
            check($sformatf("remain_u%0d", i), 32'(rem[i]), 32'(er));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            kind[i] = nkind[i];
            left[i] = nleft[i];
        end
        if (rst_n) armed = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
            advance();
        end
    endtask

    initial begin
        armed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            kind[i] = K_NONE; left[i] = 0;
        end
        // Reset held with a redirect pending, then the quiet cycle after release
        drive(0, 7'h6f, 5'd0, 5'd0, 0, 5'd0, 1);
        check("rst_quiet", 32'({fif, fid, spc}), 32'd0);
        advance();
        drive(0, 7'h6f, 5'd0, 5'd0, 0, 5'd0, 1);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 1);
        check("post_rst_quiet", 32'({fif, fid, bsy}), 32'd0);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 1);
        check("redirect_live", 32'({fif[0], fid[0]}), 32'b11);
        advance();
        idle(3);

        // Single JAL on default params: two flush cycles, remain 1 then 0
        drive(1, 7'h6f, 5'd0, 5'd0, 0, 5'd0, 0);
        check("jal_c1", 32'({fif[0], rem[0]}), 32'b1_01);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("jal_c2", 32'({fif[0], rem[0], bsy[0]}), 32'b1_00_1);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("jal_c3", 32'({fif[0], bsy[0]}), 32'b00);
        advance();
        idle(2);

        // Redirect aborts a 3-cycle JAL window on the long instance
        drive(1, 7'h6f, 5'd0, 5'd0, 0, 5'd0, 0); advance();
        drive(1, 7'h6f, 5'd0, 5'd0, 0, 5'd0, 1);
        check("abort_c1", 32'({fif[1], fid[1], rem[1]}), 32'b11_01);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("abort_c2", 32'({fif[1], fid[1], rem[1]}), 32'b11_00);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("abort_c3", 32'({fif[1], fid[1], bsy[1]}), 32'b000);
        advance();
        idle(3);

        // Load-use on rs2, then a load to x0 that must not stall
        drive(1, 7'h00, 5'd0, 5'd5, 1, 5'd5, 0);
        check("lu_c1", 32'({spc[1], sif[1], fid[1]}), 32'b111);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("lu_c2", 32'({spc[1], sif[1], fid[1], rem[1]}), 32'b111_00);
        advance();
        idle(3);
        drive(1, 7'h00, 5'd0, 5'd0, 1, 5'd0, 0);
        check("lu_x0", 32'({spc, sif}), 32'd0);
        advance();

        // All three hazards at once: redirect wins
        drive(1, 7'h6f, 5'd3, 5'd0, 1, 5'd3, 1);
        check("prio_c1", 32'({spc[0], fif[0], fid[0]}), 32'b011);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("prio_busy", 32'(bsy[0]), 32'd1);
        advance();
        idle(3);

        // Redirect disabled on u_nobr; reset pulse in the middle of its 3-cycle stall
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 1);
        check("br_off", 32'({fif[2], fid[2]}), 32'd0);
        advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("br_off_idle", 32'(bsy[2]), 32'd0);
        advance();
        idle(2);
        drive(1, 7'h00, 5'd7, 5'd0, 1, 5'd7, 0); advance();
        drive(1, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("lstall_busy", 32'({bsy[2], rem[2]}), 32'b1_01);
        advance();
        drive(0, 7'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        check("rst_mid", 32'({spc[2], bsy[2]}), 32'd0);
        advance();
        idle(3);

        // Random traffic with occasional reset pulses
        for (int k = 0; k < 3000; k++) begin
            logic [6:0] op;
            op = ($urandom_range(3) == 0) ? 7'h6f : 7'($urandom);
            drive(($urandom_range(99) != 0), op, 5'($urandom_range(3)), 5'($urandom_range(3)),
                  ($urandom_range(2) == 0), 5'($urandom_range(3)), ($urandom_range(7) == 0));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
